receptor_fifo: RTL and testbench
================================

RECEPTOR_FIFO -- requirements
Module: receptor_fifo

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of FIFO entries and SHALL be a power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: the reset, which SHALL be synchronous and active-high.
REQ-005 Port send, input, 1: four-phase request from the upstream sender; it is asynchronous to clk.
REQ-006 Port dados, input, WIDTH: data word, held stable by the sender while send=1 and ack=0.
REQ-007 Port ack, output, 1: four-phase acknowledge to the sender, registered.
REQ-008 Port dout, output, WIDTH: head-of-FIFO word, first-word-fall-through.
REQ-009 Port dout_valid, output, 1: SHALL be high whenever the FIFO is not empty.
REQ-010 Port dout_ready, input, 1: consumer accept; a pop occurs on any edge where dout_valid=1 and dout_ready=1.
REQ-011 Port count, output, $clog2(DEPTH+1): number of stored words.
REQ-012 Port full, output, 1: SHALL equal (count==DEPTH).
REQ-013 Port empty, output, 1: SHALL equal (count==0).

Function
REQ-014 send SHALL pass through a two-flop synchronizer; the second flop output is send_s, and only send_s SHALL drive control.
REQ-015 Handshake FSM states SHALL be WAIT_SEND and WAIT_DROP.
REQ-016 WAIT_SEND with send_s=1 and full=0 SHALL on the same edge:
  - write dados at wr_ptr,
  - set ack=1,
  - go to WAIT_DROP.
REQ-017 WAIT_SEND with send_s=1 and full=1 SHALL hold ack=0 and remain in WAIT_SEND (backpressure).
REQ-018 WAIT_DROP with send_s=0 SHALL clear ack and return to WAIT_SEND; with send_s=1 it SHALL hold ack=1.
REQ-019 Latency: if send is first sampled high at edge k, the write and the ack rise SHALL occur at edge k+2 (FIFO not full).
REQ-020 Exactly one word SHALL be written per four-phase transaction.
REQ-021 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-022 count SHALL change as follows:
  - +1 on push only,
  - -1 on pop only,
  - unchanged on a simultaneous push and pop.
REQ-023 The full decision SHALL use the registered count, so a pop in the same cycle SHALL NOT enable a push when full=1.
REQ-024 Pop while empty SHALL be impossible because dout_valid=0; dout_ready SHALL be ignored when empty.
REQ-025 A push into an empty FIFO SHALL make dout_valid=1 and dout show the word one cycle after the write edge.

Reset
REQ-026 Reset SHALL set:
  - ack=0, state=WAIT_SEND, both synchronizer flops=0,
  - wr_ptr=0, rd_ptr=0, count=0,
  - full=0, empty=1, dout_valid=0.
REQ-027 FIFO storage SHALL NOT be reset; dout is don't-care while dout_valid=0.
REQ-028 Reset during WAIT_DROP SHALL drop ack on the reset edge and discard all stored words.
REQ-029 A send still high after reset release SHALL be treated as a new request.

Structure
REQ-030 Package receptor_pkg SHALL hold the FSM state enum (WAIT_SEND, WAIT_DROP) and the default WIDTH and DEPTH constants.
REQ-031 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, clk/rst, reset value 0); everything else SHALL be in receptor_fifo.

Verification
REQ-032 Single word: after reset, dados=4'hA and send=1 -> ack=1 two edges after first sampling; dout=4'hA; dout_valid=1; count=1; then send=0 -> ack=0 within 3 edges.
REQ-033 Fill and backpressure: 5 transactions (1,2,3,4,5) with dout_ready=0 -> full=1 after the 4th; 5th ack stays 0; pop one -> 5th completes; reads return 1,2,3,4,5.
REQ-034 Wrap-around: 10 transactions with dout_ready=1 -> output order matches input order; count never exceeds 1; pointers wrap without loss.
REQ-035 Simultaneous push and pop: count=2, pop on the write edge -> count remains 2 and order is preserved.
REQ-036 Reset mid-handshake: rst=1 while ack=1 with count=3 -> next edge ack=0, count=0, empty=1; a held send after release causes one new write.

Source files
------------

// File: rtl/receptor_pkg.sv
// Shared types and default sizing for the four-phase receptor FIFO.
package receptor_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    WAIT_SEND = 1'b0,
    WAIT_DROP = 1'b1
  } state_t;

endpackage

// File: rtl/receptor_fifo_if.sv
// Sender/consumer bundle of the receptor FIFO; the FIFO takes the slave side.
interface receptor_fifo_if
  import receptor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic                         send;
  logic [WIDTH-1:0]             dados;
  logic                         ack;
  logic [WIDTH-1:0]             dout;
  logic                         dout_valid;
  logic                         dout_ready;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;
  logic                         empty;

  modport master (
    output send, dados, dout_ready,
    input  ack, dout, dout_valid, count, full, empty
  );

  modport slave (
    input  send, dados, dout_ready,
    output ack, dout, dout_valid, count, full, empty
  );

endinterface

// File: rtl/receptor_fifo_sync_2ff.sv
// Two-flop synchronizer for the asynchronous send request, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receptor_fifo.sv
// Four-phase handshake receiver feeding a first-word-fall-through FIFO.
//   state     | meaning
//   WAIT_SEND | ack low, waiting for a synchronized request with room in the FIFO
//   WAIT_DROP | word stored, ack high, waiting for the sender to drop send
module receptor_fifo
  import receptor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  receptor_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             send_s;
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic             ack_w;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.send),
    .q   (send_s)
  );

  // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SEND;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SEND: if (send_s && !full_w) state_d = WAIT_DROP;
      WAIT_DROP: if (!send_s)           state_d = WAIT_SEND;
      default:                          state_d = WAIT_SEND;
    endcase
  end

  always_comb begin
    push  = 1'b0;
    ack_w = 1'b0;
    case (state_q)
      WAIT_SEND: push  = send_s && !full_w;
      WAIT_DROP: ack_w = 1'b1;
      default: begin
        push  = 1'b0;
        ack_w = 1'b0;
      end
    endcase
  end

  assign pop = !empty_w && bus.dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= bus.dados;
  end

  assign bus.ack        = ack_w;
  assign bus.dout       = mem[rd_ptr];
  assign bus.dout_valid = !empty_w;
  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;

endmodule

// File: tb/tb_receptor_fifo.sv
// Bench for receptor_fifo: vector table, directed corner sequences, and a queue-model scoreboard.
module tb_receptor_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  receptor_fifo_if #(.WIDTH(4), .DEPTH(4)) bus ();

  receptor_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic       send;
    logic [3:0] dados;
    logic       rdy;
    logic       ack;
    logic [2:0] cnt;
    logic       valid;
    logic       full;
    logic       empty;
    logic       dchk;
    logic [3:0] dout;
  } vec_t;

  vec_t vt[9];

  int    q[$];
  bit    mon_en     = 0;
  bit    rnd_ready  = 0;
  int    max_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.send = 1'b0;
    bus.dados = 4'h0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.ack !== val && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.ack, val);
  endtask

  task automatic xfer(input logic [3:0] d);
    bus.send  = 1'b1;
    bus.dados = d;
    wait_ack(1'b1, 200, "xfer_ack_rise");
    bus.send = 1'b0;
    wait_ack(1'b0, 20, "xfer_ack_fall");
  endtask

  task automatic pop_one(input logic [3:0] exp, input string name);
    chk({name, "_valid"}, bus.dout_valid, 1);
    chk(name, bus.dout, exp);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  // Scoreboard: a plain queue of accepted words; a pop is whatever the consumer asked for while words exist.
  logic       p_ready, p_ack;
  logic [3:0] p_dout, p_dados;
  logic       p_valid;
  bit         armed = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      armed = 0;
    end else begin
      if (armed) begin
        if (q.size() > 0 && p_ready) begin
          chk("mon_valid_at_pop", p_valid, 1);
          chk("mon_dout", p_dout, q[0]);
          void'(q.pop_front());
        end
        if (bus.ack && !p_ack) begin
          chk("mon_push_room", (q.size() < 4), 1);
          q.push_back(p_dados);
        end
        chk("mon_count", bus.count, q.size());
        chk("mon_full", bus.full, (q.size() == 4));
        chk("mon_empty", bus.empty, (q.size() == 0));
        chk("mon_dout_valid", bus.dout_valid, (q.size() != 0));
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      end
      p_ready = bus.dout_ready;
      p_ack   = bus.ack;
      p_dout  = bus.dout;
      p_dados = bus.dados;
      p_valid = bus.dout_valid;
      armed   = 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //          rst send dados rdy | ack cnt valid full empty dchk dout
    vt[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vt[1] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vt[2] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vt[3] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[4] = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[5] = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[6] = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA};
    vt[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vt[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};

    rst = 1'b1;
    bus.send = 1'b0;
    bus.dados = 4'h0;
    bus.dout_ready = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      rst            = vt[i].rst;
      bus.send       = vt[i].send;
      bus.dados      = vt[i].dados;
      bus.dout_ready = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_ack", i),   bus.ack,        vt[i].ack);
      chk($sformatf("vec%0d_count", i), bus.count,      vt[i].cnt);
      chk($sformatf("vec%0d_valid", i), bus.dout_valid, vt[i].valid);
      chk($sformatf("vec%0d_full", i),  bus.full,       vt[i].full);
      chk($sformatf("vec%0d_empty", i), bus.empty,      vt[i].empty);
      if (vt[i].dchk) chk($sformatf("vec%0d_dout", i), bus.dout, vt[i].dout);
    end

    // Fill to full, then a fifth request must stall until one word is popped.
    do_reset();
    for (int i = 1; i <= 4; i++) xfer(4'(i));
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 4);
    bus.send  = 1'b1;
    bus.dados = 4'h5;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_ack_held_low", bus.ack, 0);
    chk("bp_count", bus.count, 4);
    pop_one(4'h1, "bp_pop1");
    wait_ack(1'b1, 10, "bp_fifth_ack");
    chk("bp_count_after", bus.count, 4);
    bus.send = 1'b0;
    wait_ack(1'b0, 10, "bp_fifth_drop");
    pop_one(4'h2, "bp_pop2");
    pop_one(4'h3, "bp_pop3");
    pop_one(4'h4, "bp_pop4");
    pop_one(4'h5, "bp_pop5");
    chk("bp_empty_end", bus.empty, 1);

    // Pop lands on the same edge as a write: count holds, order is kept.
    do_reset();
    xfer(4'h7);
    xfer(4'h8);
    chk("pp_count_pre", bus.count, 2);
    bus.send  = 1'b1;
    bus.dados = 4'h9;
    tick();
    tick();
    chk("pp_ack_pre", bus.ack, 0);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("pp_ack_write", bus.ack, 1);
    chk("pp_count_same", bus.count, 2);
    chk("pp_head", bus.dout, 4'h8);
    bus.send = 1'b0;
    wait_ack(1'b0, 10, "pp_drop");
    pop_one(4'h8, "pp_pop8");
    pop_one(4'h9, "pp_pop9");

    // Reset while ack is high: everything cleared, held send becomes exactly one new write.
    do_reset();
    xfer(4'h1);
    xfer(4'h2);
    bus.send  = 1'b1;
    bus.dados = 4'hC;
    wait_ack(1'b1, 10, "rst_ack_up");
    chk("rst_count_pre", bus.count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ack", bus.ack, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_valid", bus.dout_valid, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("rst_new_ack", bus.ack, 1);
    chk("rst_new_count", bus.count, 1);
    bus.send = 1'b0;
    wait_ack(1'b0, 10, "rst_new_drop");
    for (int i = 0; i < 4; i++) tick();
    chk("rst_one_write", bus.count, 1);
    chk("rst_new_dout", bus.dout, 4'hC);

    // Wrap-around with an always-ready consumer, checked by the scoreboard.
    do_reset();
    q.delete();
    max_cnt = 0;
    bus.dout_ready = 1'b1;
    mon_en = 1;
    for (int i = 0; i < 10; i++) xfer(4'(i + 3));
    n = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    chk("wrap_drained", q.size(), 0);
    chk("wrap_max_count", (max_cnt <= 1), 1);
    mon_en = 0;
    tick();

    // Random data, random gaps, random consumer readiness.
    do_reset();
    q.delete();
    mon_en = 1;
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      xfer(4'($urandom_range(0, 15)));
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) tick();
    end
    rnd_ready = 0;
    bus.dout_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    tick();
    chk("rand_drained", q.size(), 0);
    chk("rand_empty", bus.empty, 1);
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
